// File: rtl/dreg_universal.sv
// dreg_universal: WIDTH-bit register with hold/load/shift-left/shift-right modes,
// serial in/out, complementary outputs, synchronous clear and a sticky loaded flag.
module dreg_universal #(
  parameter int WIDTH = 4,
  parameter bit ROTATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button2_rst_n_2,
  input  logic             input_switch3_clr_3,
  input  logic [1:0]       input_switch4_mode_4,
  input  logic [WIDTH-1:0] input_switch5_d_5,
  input  logic             input_switch6_sil_6,
  input  logic             input_switch7_sir_7,
  output logic [WIDTH-1:0] output_led1_q_8,
  output logic [WIDTH-1:0] output_led2_qn_9,
  output logic             output_led3_so_10,
  output logic             output_led4_loaded_11
);
  logic [WIDTH-1:0] q, q_next;
  logic loaded;
  logic fill_l, fill_r;
  logic [1:0] mode;
  assign mode = input_switch4_mode_4;
  // End bit fed into the vacated position: recirculated or serial input
  assign fill_l = ROTATE ? q[WIDTH-1] : input_switch6_sil_6;
  assign fill_r = ROTATE ? q[0] : input_switch7_sir_7;
  always_comb
    q_next = input_switch3_clr_3 ? '0 :
             mode == 2'b01 ? input_switch5_d_5 :
             mode == 2'b10 ? {q[WIDTH-2:0], fill_l} :
             mode == 2'b11 ? {fill_r, q[WIDTH-1:1]} : q;
  always_ff @(posedge input_clock1_clk_1 or negedge input_push_button2_rst_n_2)
    if (!input_push_button2_rst_n_2) begin
      q <= RESET_VALUE;
      loaded <= 1'b0;
    end else begin
      q <= q_next;
      loaded <= loaded | input_switch3_clr_3 | (mode == 2'b01);
    end
  assign output_led1_q_8 = q;
  assign output_led2_qn_9 = ~q;
  assign output_led3_so_10 = mode == 2'b10 ? q[WIDTH-1] : q[0];
  assign output_led4_loaded_11 = loaded;
endmodule

// File: tb/tb_dreg_universal.sv
// tb_dreg_universal: directed checks of two dreg_universal configurations
// (4-bit shift, reset value 1010; 8-bit rotate) against an arithmetic model.
module tb_dreg_universal;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_a = 1'b0, sil_a = 1'b0, sir_a = 1'b0;
  logic [1:0] mode_a = 2'b00;
  logic [3:0] d_a = '0;
  logic clr_b = 1'b0, sil_b = 1'b0, sir_b = 1'b0;
  logic [1:0] mode_b = 2'b00;
  logic [7:0] d_b = '0;
  logic [3:0] q_a, qn_a;
  logic so_a, ld_a;
  logic [7:0] q_b, qn_b;
  logic so_b, ld_b;
  logic [3:0] ma;
  logic mla;
  logic [7:0] mb;
  logic mlb;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dreg_universal #(.WIDTH(4), .ROTATE(1'b0), .RESET_VALUE(4'b1010)) dut_a (
    .input_clock1_clk_1(clk), .input_push_button2_rst_n_2(rst_n),
    .input_switch3_clr_3(clr_a), .input_switch4_mode_4(mode_a),
    .input_switch5_d_5(d_a), .input_switch6_sil_6(sil_a), .input_switch7_sir_7(sir_a),
    .output_led1_q_8(q_a), .output_led2_qn_9(qn_a),
    .output_led3_so_10(so_a), .output_led4_loaded_11(ld_a));

  dreg_universal #(.WIDTH(8), .ROTATE(1'b1), .RESET_VALUE(8'h00)) dut_b (
    .input_clock1_clk_1(clk), .input_push_button2_rst_n_2(rst_n),
    .input_switch3_clr_3(clr_b), .input_switch4_mode_4(mode_b),
    .input_switch5_d_5(d_b), .input_switch6_sil_6(sil_b), .input_switch7_sir_7(sir_b),
    .output_led1_q_8(q_b), .output_led2_qn_9(qn_b),
    .output_led3_so_10(so_b), .output_led4_loaded_11(ld_b));

  // Model: shifts as multiply/divide by two with the fill bit added in
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma <= 4'b1010; mla <= 1'b0;
      mb <= 8'h00; mlb <= 1'b0;
    end else begin
      if (clr_a) begin ma <= 4'd0; mla <= 1'b1; end
      else if (mode_a == 2'd1) begin ma <= d_a; mla <= 1'b1; end
      else if (mode_a == 2'd2) ma <= 4'((ma * 2) + {3'd0, sil_a});
      else if (mode_a == 2'd3) ma <= 4'((ma / 2) + (sir_a ? 8 : 0));
      if (clr_b) begin mb <= 8'd0; mlb <= 1'b1; end
      else if (mode_b == 2'd1) begin mb <= d_b; mlb <= 1'b1; end
      else if (mode_b == 2'd2) mb <= 8'((mb * 2) + (mb / 128));
      else if (mode_b == 2'd3) mb <= 8'((mb / 2) + ((mb % 2) * 128));
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("q_a", 32'(q_a), 32'(ma));
    chk("qn_a", 32'(qn_a), 32'(4'(~ma)));
    chk("so_a", 32'(so_a), 32'(mode_a == 2'd2 ? ma / 8 : ma % 2));
    chk("loaded_a", 32'(ld_a), 32'(mla));
    chk("q_b", 32'(q_b), 32'(mb));
    chk("qn_b", 32'(qn_b), 32'(8'(~mb)));
    chk("so_b", 32'(so_b), 32'(mode_b == 2'd2 ? mb / 128 : mb % 2));
    chk("loaded_b", 32'(ld_b), 32'(mlb));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] sil_seq, so_seq;
    logic [15:0] q_seq;
    sil_seq = 4'b1101;
    so_seq = 4'b1000;
    q_seq = 16'hBD63;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_q", 32'(q_a), 32'h0000000A);
    chk("rst_qn", 32'(qn_a), 32'h00000005);
    chk("rst_loaded", 32'(ld_a), 32'h0);
    chk("rst_qn_b", 32'(qn_b), 32'h000000FF);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("hold_after_rst", 32'(q_a), 32'h0000000A);
    chk("hold_loaded", 32'(ld_a), 32'h0);
    d_a = 4'b0110; mode_a = 2'b01;
    tick(1);
    chk("load_q", 32'(q_a), 32'h6);
    chk("load_qn", 32'(qn_a), 32'h9);
    chk("load_loaded", 32'(ld_a), 32'h1);
    d_a = 4'b1111; mode_a = 2'b00;
    tick(2);
    chk("hold_q", 32'(q_a), 32'h6);
    d_a = 4'b0001; mode_a = 2'b01;
    tick(1);
    mode_a = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sil_a = sil_seq[i];
      #1;
      chk("shl_so", 32'(so_a), 32'(so_seq[i]));
      tick(1);
      chk("shl_q", 32'(q_a), 32'(q_seq[4*i +: 4]));
    end
    mode_a = 2'b00;
    d_b = 8'h81; mode_b = 2'b01;
    tick(1);
    mode_b = 2'b11; sir_b = 1'b1; sil_b = 1'b1;
    tick(1);
    chk("rotr_1", 32'(q_b), 32'hC0);
    for (int i = 0; i < 7; i++) begin
      sir_b = ~sir_b;
      tick(1);
    end
    chk("rotr_8", 32'(q_b), 32'h81);
    mode_b = 2'b10;
    tick(8);
    chk("rotl_8", 32'(q_b), 32'h81);
    mode_b = 2'b00;
    d_a = 4'b1111; mode_a = 2'b01;
    tick(1);
    clr_a = 1'b1; d_a = 4'b0101;
    tick(1);
    chk("clr_q", 32'(q_a), 32'h0);
    chk("clr_loaded", 32'(ld_a), 32'h1);
    clr_a = 1'b0; mode_a = 2'b11; sir_a = 1'b1;
    tick(1);
    chk("shr_sir", 32'(q_a), 32'h8);
    d_a = 4'b0011; mode_a = 2'b01;
    tick(1);
    mode_a = 2'b10; sil_a = 1'b0;
    tick(1);
    chk("pre_async", 32'(q_a), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", 32'(q_a), 32'hA);
    chk("async_qn", 32'(qn_a), 32'h5);
    chk("async_loaded", 32'(ld_a), 32'h0);
    #1 rst_n = 1'b1;
    tick(1);
    chk("post_async_shift", 32'(q_a), 32'h4);
    chk("shift_no_loaded", 32'(ld_a), 32'h0);
    clr_a = 1'b1; mode_a = 2'b00;
    tick(1);
    chk("clr_sets_loaded", 32'(ld_a), 32'h1);
    clr_a = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dreg_universal.md
Name: dreg_universal

Overview:
- Parametrised successor to the single-bit D latch/flip-flop cells.
- WIDTH-bit edge-triggered storage register with four operating modes: hold, parallel load, shift left and shift right.
- Has serial in/out, complementary outputs, a synchronous clear, and a per-reset "loaded" flag.
- Used as the standard storage/shift element for exported multi-bit circuits: counters, serial links, LED banks.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- ROTATE, 0, when 1 the shift modes recirculate the end bit instead of taking the serial input.
- RESET_VALUE, 0, WIDTH-bit value loaded into Q on asynchronous reset.

Ports:
- input_clock1_clk_1  input  1  clock, rising-edge active.
- input_push_button2_rst_n_2  input  1  asynchronous reset, active-low.
- input_switch3_clr_3  input  1  synchronous clear, active-high.
- input_switch4_mode_4  input  2  mode: 00 hold, 01 load, 10 shift left, 11 shift right.
- input_switch5_d_5  input  WIDTH  parallel data.
- input_switch6_sil_6  input  1  serial in for shift left; enters at bit 0.
- input_switch7_sir_7  input  1  serial in for shift right; enters at bit WIDTH-1.
- output_led1_q_8  output  WIDTH  register contents Q.
- output_led2_qn_9  output  WIDTH  ~Q, bitwise complement.
- output_led3_so_10  output  1  serial out: Q[WIDTH-1] in mode 10, Q[0] in all other modes.
- output_led4_loaded_11  output  1  set after the first load or clear since reset.

Behaviour:
- Clocking and reset:
  - One clock, one clock domain; all state changes on the rising edge except reset.
  - Reset asserted (rst_n=0): immediately Q=RESET_VALUE, loaded=0, regardless of clock.
  - Reset deassertion is honoured at the next rising edge; no state change on the deasserting edge itself.
- Priority at each rising edge with rst_n=1: clr > mode.
  - clr=1: Q <= 0, loaded <= 1; mode ignored.
  - mode 00: Q <= Q.
  - mode 01: Q <= D, loaded <= 1.
  - mode 10, ROTATE=0: Q <= {Q[WIDTH-2:0], sil}.
  - mode 10, ROTATE=1: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - mode 11, ROTATE=0: Q <= {sir, Q[WIDTH-1:1]}.
  - mode 11, ROTATE=1: Q <= {Q[0], Q[WIDTH-1:1]}.
- Outputs:
  - Q, qn, so and loaded are purely registered or decoded from registered state plus mode; qn is never X once reset has been applied.
  - Complement invariant holds every cycle, including during reset: qn == ~Q.
  - so is combinational from Q and mode, giving zero-latency serial out. The bit shown is the one that will be shifted out at the next edge.
- Latency: one clock from input change to Q update in every mode.
- loaded flag: sticky; cleared only by asynchronous reset; shift and hold never set it.
- Boundary cases:
  - Shift with ROTATE=0: the vacated end bit is fed only from the serial input; WIDTH shifts fully replace Q with serial data.
  - ROTATE=1: WIDTH consecutive shifts in one direction return Q to its original value; sil and sir are ignored.
  - clr and mode 01 in the same cycle: clear wins, Q=0.
  - Reset asserted mid-shift: Q returns to RESET_VALUE asynchronously; the interrupted shift is lost.
  - Mode change between cycles takes effect on the very next edge, with no pipeline bubble.
- No X propagation from undriven serial inputs while in hold or load.

Test Plan:
- Reset, WIDTH=4, RESET_VALUE=4'b1010: rst_n=0 with no clock -> Q=1010, qn=0101, loaded=0. Release rst_n, mode 00, 3 clocks -> Q still 1010.
- Parallel load, WIDTH=4: D=0110, mode 01, one edge -> Q=0110, qn=1001, loaded=1. Then D=1111, mode 00, 2 edges -> Q stays 0110.
- Shift left, ROTATE=0, WIDTH=4: from Q=0001, mode 10, sil sequence 1,0,1,1 over 4 edges -> Q goes 0011, 0110, 1101, 1011; so before each edge shows 0,0,0,1.
- Rotate right, ROTATE=1, WIDTH=8: load 8'h81, mode 11, 8 edges -> Q=81 again; after 1 edge Q=C0; sir toggling has no effect.
- Clear priority: Q=1111, clr=1 together with mode 01 and D=0101 -> Q=0000, loaded=1. Then clr=0, shift right with sir=1, one edge -> Q=1000.
- Asynchronous reset mid-operation: during shift-left run at Q=0110, pulse rst_n low between edges -> Q=RESET_VALUE before the next edge, loaded=0, qn complement holds throughout.
